// File: rtl/cache_line_fill_ctrl_pkg.sv
// Shared constants for the direct-mapped cache and its line-fill controller:
// geometry, request type codes and the fill FSM state encoding.
package cache_defs;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int BEATS       = 4;
  localparam int MEM_AW      = ADDR_WIDTH - $clog2(DATA_WIDTH / 8);
  localparam int READ_LAT    = 2;
  localparam int BLOCK_BYTES = BEATS * DATA_WIDTH / 8;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [2:0] {
    FILL_IDLE     = 3'd0,
    FILL_RD_ISSUE = 3'd1,
    FILL_RD_DRAIN = 3'd2,
    FILL_WR_BEAT  = 3'd3,
    FILL_RESP     = 3'd4
  } fill_state_t;

endpackage

// File: rtl/cache_line_fill_ctrl_rd_lat_tracker.sv
// Valid-bit delay line matching the memory read latency; a bit issued with a
// read pops out on valid_out exactly when that read's data appears on mem_rdata.
module rd_lat_tracker #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic flush,
  input  logic issue,
  output logic valid_out,
  output logic pending
);

  logic [DEPTH-1:0] pipe_reg;
  logic [DEPTH-1:0] pipe_next;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign pipe_next[gi] = issue;
      end else begin : g_body
        assign pipe_next[gi] = pipe_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (flush) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg <= pipe_next;
    end
  end

  assign valid_out = pipe_reg[DEPTH-1];

  // Reads still travelling behind the one currently at the output.
  generate
    if (DEPTH > 1) begin : g_pend
      assign pending = |pipe_reg[DEPTH-2:0];
    end else begin : g_nopend
      assign pending = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Turns one block-aligned cache request into a BEATS-word burst on a
// single-port synchronous SRAM; read beats return in order, lowest word first.
module cache_line_fill_ctrl #(
  parameter int ADDR_WIDTH = cache_defs::ADDR_WIDTH,
  parameter int DATA_WIDTH = cache_defs::DATA_WIDTH,
  parameter int BEATS      = cache_defs::BEATS,
  parameter int MEM_AW     = cache_defs::MEM_AW,
  parameter int READ_LAT   = cache_defs::READ_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  import cache_defs::*;

  localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);
  localparam int BLK_SH  = $clog2(BEATS * DATA_WIDTH / 8);
  localparam int CW      = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  fill_state_t       state_reg, state_next;
  logic [MEM_AW-1:0] base_reg, base_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic              issue;
  logic              trk_valid;
  logic              trk_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL_IDLE;
      base_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    done       = 1'b0;
    // Word address wraps modulo 2^MEM_AW by truncation.
    mem_addr   = base_reg + MEM_AW'(cnt_reg);

    case (state_reg)
      FILL_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (|req_addr[BLK_SH-1:0]) begin
            err_next = 1'b1;
          end else begin
            base_next  = MEM_AW'(req_addr >> BYTE_SH);
            cnt_next   = '0;
            state_next = (req_write == REQ_WRITE) ? FILL_WR_BEAT : FILL_RD_ISSUE;
          end
        end
      end
      FILL_RD_ISSUE: begin
        mem_en   = 1'b1;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST_BEAT) begin
          state_next = FILL_RD_DRAIN;
        end
      end
      FILL_RD_DRAIN: begin
        if (trk_valid && !trk_pending) begin
          state_next = FILL_RESP;
        end
      end
      FILL_WR_BEAT: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = wr_data;
          cnt_next  = cnt_reg + CW'(1);
          if (cnt_reg == LAST_BEAT) begin
            state_next = FILL_RESP;
          end
        end
      end
      FILL_RESP: begin
        done       = 1'b1;
        state_next = FILL_IDLE;
      end
      default: begin
        state_next = FILL_IDLE;
      end
    endcase

    // Reset silences every output in the cycle it is sampled, so an
    // interrupted burst issues nothing further.
    if (rst) begin
      req_ready = 1'b0;
      wr_ready  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      done      = 1'b0;
    end
  end

  assign issue = mem_en & ~mem_we;

  rd_lat_tracker #(
    .DEPTH(READ_LAT)
  ) u_rd_lat_tracker (
    .clk      (clk),
    .flush    (rst),
    .issue    (issue),
    .valid_out(trk_valid),
    .pending  (trk_pending)
  );

  assign err      = err_reg & ~rst;
  assign rd_valid = trk_valid & ~rst;
  assign rd_data  = rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Bench for cache_line_fill_ctrl: directed scenarios plus random block traffic
// checked against an event-list model with an SRAM stand-in on the memory port.
module tb_cache_line_fill_ctrl;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int B   = 4;
  localparam int L   = 2;
  localparam int MAW = 30;

  logic           clk;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [AW-1:0]  req_addr;
  logic           req_write;
  logic           wr_valid;
  logic           wr_ready;
  logic [DW-1:0]  wr_data;
  logic           rd_valid;
  logic [DW-1:0]  rd_data;
  logic           done;
  logic           err;
  logic           mem_en;
  logic           mem_we;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;

  // Narrow-address twin: same stimulus, only its address wrap is observed.
  logic           req_ready8, wr_ready8, rd_valid8, done8, err8, mem_en8, mem_we8;
  logic [DW-1:0]  rd_data8, mem_wdata8;
  logic [7:0]     mem_addr8;

  cache_line_fill_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(B), .MEM_AW(MAW), .READ_LAT(L)
  ) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .rd_valid(rd_valid),
    .rd_data(rd_data), .done(done), .err(err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  cache_line_fill_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(B), .MEM_AW(8), .READ_LAT(L)
  ) u_dut8 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready8),
    .req_addr(req_addr), .req_write(req_write), .wr_valid(wr_valid),
    .wr_ready(wr_ready8), .wr_data(wr_data), .rd_valid(rd_valid8),
    .rd_data(rd_data8), .done(done8), .err(err8), .mem_en(mem_en8),
    .mem_we(mem_we8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM stand-in: word k starts out holding k*0x11 (aliased on 12 bits).
  bit [31:0] sram [4096];
  bit        sram_w [4096];
  bit [31:0] rpipe [L];
  bit [31:0] ref_mem [4096];
  bit        ref_w [4096];

  function automatic bit [31:0] sram_word(input logic [MAW-1:0] a);
    return sram_w[a[11:0]] ? sram[a[11:0]] : 32'(a[11:0]) * 32'h11;
  endfunction

  function automatic bit [31:0] ref_word(input logic [MAW-1:0] a);
    return ref_w[a[11:0]] ? ref_mem[a[11:0]] : 32'(a[11:0]) * 32'h11;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      sram[mem_addr[11:0]]   <= mem_wdata;
      sram_w[mem_addr[11:0]] <= 1'b1;
    end
    rpipe[0] <= (mem_en && !mem_we) ? sram_word(mem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[L-1];

  typedef struct packed {
    int unsigned    cyc;
    logic           we;
    logic [MAW-1:0] addr;
    logic [8:0]     a8;
    logic [31:0]    data;
  } acc_t;

  typedef struct packed {
    int unsigned cyc;
    logic [31:0] data;
  } beat_t;

  acc_t        obs_acc[$], exp_acc[$];
  beat_t       obs_rd[$],  exp_rd[$];
  int unsigned obs_done[$], exp_done[$];
  int unsigned obs_err[$],  exp_err[$];
  int          bad_we = 0;

  always @(negedge clk) begin : monitor
    acc_t  e;
    beat_t b;
    if (mem_en) begin
      e.cyc = cyc; e.we = mem_we; e.addr = mem_addr;
      e.a8 = {mem_en8, mem_addr8}; e.data = mem_wdata;
      obs_acc.push_back(e);
    end
    if (rd_valid) begin
      b.cyc = cyc; b.data = rd_data;
      obs_rd.push_back(b);
    end
    if (done) obs_done.push_back(cyc);
    if (err)  obs_err.push_back(cyc);
    if (mem_we && !mem_en) bad_we++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Waits (bounded) for req_ready, returns the cycle the request was taken.
  task automatic present_req(input logic [31:0] a, input logic w, output int t);
    logic r;
    req_addr  = a;
    req_write = w;
    req_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 32; i++) begin
      r = req_ready;
      @(posedge clk); #1;
      if (r) begin
        t = int'(cyc) - 1;
        break;
      end
    end
    req_valid = 1'b0;
    if (t < 0) check("req_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic rd_txn(input logic [31:0] a, output int t);
    acc_t           e;
    beat_t          b;
    logic [MAW-1:0] wa;
    present_req(a, 1'b0, t);
    if (t < 0) return;
    if (a % 32'(B * DW / 8) != 0) begin
      exp_err.push_back(t + 1);
      return;
    end
    for (int k = 0; k < B; k++) begin
      wa = MAW'(a / 4) + MAW'(k);
      e.cyc = t + 1 + k; e.we = 1'b0; e.addr = wa; e.a8 = {1'b1, wa[7:0]}; e.data = '0;
      exp_acc.push_back(e);
      b.cyc = t + 1 + L + k; b.data = ref_word(wa);
      exp_rd.push_back(b);
    end
    exp_done.push_back(t + 1 + L + B);
    repeat (L + B + 1) begin @(posedge clk); #1; end
  endtask

  task automatic wr_txn(input logic [31:0] a, input logic [15:0] pat, input bit use_pat,
                        output int done_c);
    acc_t           e;
    logic [MAW-1:0] wa;
    logic           v;
    logic [31:0]    d;
    int             t, k;
    done_c = -1;
    present_req(a, 1'b1, t);
    if (t < 0) return;
    if (a % 32'(B * DW / 8) != 0) begin
      exp_err.push_back(t + 1);
      return;
    end
    k = 0;
    for (int i = 0; i < 64 && k < B; i++) begin
      v = use_pat ? ((i < 16) ? pat[i] : 1'b1) : ($urandom_range(0, 2) != 0);
      d = $urandom;
      wr_valid = v;
      wr_data  = d;
      check("wr_ready_beat", 64'(wr_ready), 64'd1);
      if (v) begin
        wa = MAW'(a / 4) + MAW'(k);
        e.cyc = cyc; e.we = 1'b1; e.addr = wa; e.a8 = {1'b1, wa[7:0]}; e.data = d;
        exp_acc.push_back(e);
        ref_mem[wa[11:0]] = d;
        ref_w[wa[11:0]]   = 1'b1;
        k++;
      end
      @(posedge clk); #1;
    end
    done_c = int'(cyc);
    exp_done.push_back(cyc);
    // Stray beat offered after the block completed must be ignored.
    wr_valid = 1'b1;
    wr_data  = $urandom;
    check("wr_ready_resp", 64'(wr_ready), 64'd0);
  endtask

  task automatic seg_end(input string tag);
    int n;
    wr_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check({tag, ":n_acc"}, 64'(obs_acc.size()), 64'(exp_acc.size()));
    n = (obs_acc.size() < exp_acc.size()) ? obs_acc.size() : exp_acc.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ":acc_cyc"},  64'(obs_acc[i].cyc),  64'(exp_acc[i].cyc));
      check({tag, ":acc_we"},   64'(obs_acc[i].we),   64'(exp_acc[i].we));
      check({tag, ":acc_addr"}, 64'(obs_acc[i].addr), 64'(exp_acc[i].addr));
      check({tag, ":acc_addr8"}, 64'(obs_acc[i].a8),  64'(exp_acc[i].a8));
      if (exp_acc[i].we) check({tag, ":acc_data"}, 64'(obs_acc[i].data), 64'(exp_acc[i].data));
    end
    check({tag, ":n_rd"}, 64'(obs_rd.size()), 64'(exp_rd.size()));
    n = (obs_rd.size() < exp_rd.size()) ? obs_rd.size() : exp_rd.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ":rd_cyc"},  64'(obs_rd[i].cyc),  64'(exp_rd[i].cyc));
      check({tag, ":rd_data"}, 64'(obs_rd[i].data), 64'(exp_rd[i].data));
    end
    check({tag, ":n_done"}, 64'(obs_done.size()), 64'(exp_done.size()));
    n = (obs_done.size() < exp_done.size()) ? obs_done.size() : exp_done.size();
    for (int i = 0; i < n; i++) check({tag, ":done_cyc"}, 64'(obs_done[i]), 64'(exp_done[i]));
    check({tag, ":n_err"}, 64'(obs_err.size()), 64'(exp_err.size()));
    n = (obs_err.size() < exp_err.size()) ? obs_err.size() : exp_err.size();
    for (int i = 0; i < n; i++) check({tag, ":err_cyc"}, 64'(obs_err[i]), 64'(exp_err[i]));
    check({tag, ":we_without_en"}, 64'(bad_we), 64'd0);
    $display("txn %s: accesses=%0d beats=%0d done=%0d err=%0d", tag,
             obs_acc.size(), obs_rd.size(), obs_done.size(), obs_err.size());
    obs_acc.delete(); exp_acc.delete(); obs_rd.delete(); exp_rd.delete();
    obs_done.delete(); exp_done.delete(); obs_err.delete(); exp_err.delete();
    bad_we = 0;
  endtask

  initial begin
    int          t, dc;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mem_en",    64'(mem_en),    64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_err",       64'(err),       64'd0);
    check("rst_rd_valid",  64'(rd_valid),  64'd0);
    check("rst_wr_ready",  64'(wr_ready),  64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    seg_end("reset");

    rd_txn(32'h0000_0040, t);
    seg_end("rd_0x40");

    wr_txn(32'h0000_0100, 16'b10_1101, 1'b1, dc);
    seg_end("wr_0x100");
    rd_txn(32'h0000_0100, t);
    seg_end("rb_0x100");

    rd_txn(32'h0000_0044, t);
    rd_txn(32'h0000_0080, t);
    seg_end("misaligned_0x44");

    rd_txn(32'hFFFF_FFF0, t);
    seg_end("wrap_top");

    // Reset in the second RD_ISSUE cycle abandons the burst.
    begin
      acc_t e;
      present_req(32'h0000_0200, 1'b0, t);
      e.cyc = t + 1; e.we = 1'b0; e.addr = MAW'(32'h200 / 4);
      e.a8 = {1'b1, 8'h80}; e.data = '0;
      exp_acc.push_back(e);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rstmid_req_ready_lo", 64'(req_ready), 64'd0);
      check("rstmid_mem_en",       64'(mem_en),    64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rstmid_req_ready_hi", 64'(req_ready), 64'd1);
      repeat (L + B) begin @(posedge clk); #1; end
      seg_end("rst_mid_read");
    end

    wr_txn(32'h0000_0180, 16'h0, 1'b0, dc);
    rd_txn(32'h0000_0180, t);
    check("b2b_accept_cycle", 64'(t), 64'(dc + 1));
    seg_end("b2b_wr_rd");

    for (int n = 0; n < 24; n++) begin
      a = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd16;
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) wr_txn(a, 16'h0, 1'b0, dc);
      else rd_txn(a, t);
      seg_end($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
